// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped 8-bit UART with 16-deep TX/RX FIFOs, a runtime
// baud divider, optional even/odd parity and sticky error flags.
// Bus: addr/ren/wen with a registered one-cycle read response.

module uart_fifo #(
  parameter int CLK_HZ       = 16000000,
  parameter int BAUD_DEFAULT = 1000000,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] addr,
  input  logic       ren,
  output logic [7:0] rdata,
  output logic       rd_valid,
  input  logic       wen,
  input  logic [7:0] wdata,
  output logic       tx,
  input  logic       rx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(CLK_HZ / BAUD_DEFAULT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [4:0] A_DATA = 5'h00;
  localparam logic [4:0] A_STAT = 5'h04;
  localparam logic [4:0] A_DIVL = 5'h08;
  localparam logic [4:0] A_DIVH = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------- configuration / flags / bus response ----------------
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_ctrl;
  logic             r_overrun, r_frame_err, r_par_err;
  logic [7:0]       r_rdata;
  logic             r_rd_valid;

  logic w_wr_data, w_wr_ctrl, w_rd_data;
  logic w_tx_flush, w_rx_flush, w_clr_flags;
  logic [7:0] w_stat;
  logic w_tx_busy;

  assign w_wr_data   = wen & (addr == A_DATA);
  assign w_wr_ctrl   = wen & (addr == A_CTRL);
  assign w_rd_data   = ren & (addr == A_DATA);
  assign w_tx_flush  = w_wr_ctrl & wdata[2];
  assign w_rx_flush  = w_wr_ctrl & wdata[3];
  assign w_clr_flags = w_wr_ctrl & wdata[4];

  // ---------------- TX FIFO ----------------
  logic [7:0]    r_txf_mem [FIFO_DEPTH];
  logic [PW-1:0] r_txf_wr, r_txf_rd;
  logic [CW-1:0] r_txf_cnt;
  logic [7:0]    w_txf_data;
  logic          w_txf_full, w_txf_empty, w_txf_push_ok;
  logic          w_tx_pop;

  assign w_txf_full    = (r_txf_cnt == CNT_FULL);
  assign w_txf_empty   = (r_txf_cnt == '0);
  assign w_txf_data    = r_txf_mem[r_txf_rd];
  // w_tx_pop is only raised by the TX FSM when the FIFO is non-empty
  assign w_txf_push_ok = w_wr_data & (~w_txf_full | w_tx_pop);

  // TX FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (w_txf_push_ok) r_txf_mem[r_txf_wr] <= wdata;
  end

  // TX FIFO pointers and occupancy; flush discards queued bytes only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txf_wr  <= '0;
      r_txf_rd  <= '0;
      r_txf_cnt <= '0;
    end else if (w_tx_flush) begin
      r_txf_rd  <= r_txf_wr;
      r_txf_cnt <= '0;
    end else begin
      if (w_txf_push_ok) r_txf_wr <= r_txf_wr + PTR_ONE;
      if (w_tx_pop)      r_txf_rd <= r_txf_rd + PTR_ONE;
      if (w_txf_push_ok && !w_tx_pop)      r_txf_cnt <= r_txf_cnt + CNT_ONE;
      else if (!w_txf_push_ok && w_tx_pop) r_txf_cnt <= r_txf_cnt - CNT_ONE;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    r_rxf_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rxf_wr, r_rxf_rd;
  logic [CW-1:0] r_rxf_cnt;
  logic [7:0]    w_rxf_data;
  logic          w_rxf_full, w_rxf_empty, w_rxf_push_ok, w_rxf_pop_ok;
  logic          w_rx_push;
  logic [7:0]    r_rx_shift;

  assign w_rxf_full    = (r_rxf_cnt == CNT_FULL);
  assign w_rxf_empty   = (r_rxf_cnt == '0);
  assign w_rxf_data    = r_rxf_mem[r_rxf_rd];
  assign w_rxf_pop_ok  = w_rd_data & ~w_rxf_empty;
  assign w_rxf_push_ok = w_rx_push & (~w_rxf_full | w_rxf_pop_ok);

  // RX FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (w_rxf_push_ok) r_rxf_mem[r_rxf_wr] <= r_rx_shift;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxf_wr  <= '0;
      r_rxf_rd  <= '0;
      r_rxf_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rxf_rd  <= r_rxf_wr;
      r_rxf_cnt <= '0;
    end else begin
      if (w_rxf_push_ok) r_rxf_wr <= r_rxf_wr + PTR_ONE;
      if (w_rxf_pop_ok)  r_rxf_rd <= r_rxf_rd + PTR_ONE;
      if (w_rxf_push_ok && !w_rxf_pop_ok)      r_rxf_cnt <= r_rxf_cnt + CNT_ONE;
      else if (!w_rxf_push_ok && w_rxf_pop_ok) r_rxf_cnt <= r_rxf_cnt - CNT_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  state_t           r_tx_state, w_tx_next;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
  logic [7:0]       r_tx_shift;
  logic [2:0]       r_tx_bitidx;
  logic             r_tx_par_en, r_tx_par, r_tx;
  logic             w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == '0);

  // TX next state; pops the FIFO whenever a new frame starts
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_txf_empty) begin
          w_tx_next = S_START;
          w_tx_pop  = 1'b1;
        end else begin
          w_tx_next = S_IDLE;
        end
      end
      S_START: begin
        if (w_tx_bit_end) w_tx_next = S_DATA;
        else              w_tx_next = S_START;
      end
      S_DATA: begin
        if (w_tx_bit_end && (r_tx_bitidx == 3'd7)) w_tx_next = r_tx_par_en ? S_PARITY : S_STOP;
        else                                       w_tx_next = S_DATA;
      end
      S_PARITY: begin
        if (w_tx_bit_end) w_tx_next = S_STOP;
        else              w_tx_next = S_PARITY;
      end
      S_STOP: begin
        if (w_tx_bit_end && !w_txf_empty) begin
          w_tx_next = S_START;   // back-to-back: no idle gap
          w_tx_pop  = 1'b1;
        end else if (w_tx_bit_end) begin
          w_tx_next = S_IDLE;
        end else begin
          w_tx_next = S_STOP;
        end
      end
      default: w_tx_next = S_IDLE;
    endcase
  end

  // TX state register and shifter; divider and parity mode latched per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state  <= S_IDLE;
      r_tx        <= 1'b1;
      r_tx_cnt    <= '0;
      r_tx_div    <= '0;
      r_tx_shift  <= 8'h00;
      r_tx_bitidx <= 3'd0;
      r_tx_par_en <= 1'b0;
      r_tx_par    <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_pop) begin
        r_tx        <= 1'b0;
        r_tx_shift  <= w_txf_data;
        r_tx_div    <= r_div;
        r_tx_cnt    <= r_div;
        r_tx_bitidx <= 3'd0;
        r_tx_par_en <= r_ctrl[0];
        r_tx_par    <= (^w_txf_data) ^ r_ctrl[1];
      end else if (r_tx_state == S_IDLE) begin
        r_tx <= 1'b1;
      end else if (!w_tx_bit_end) begin
        r_tx_cnt <= r_tx_cnt - DIV_ONE;
      end else begin
        r_tx_cnt <= r_tx_div;
        case (r_tx_state)
          S_START: begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end
          S_DATA: begin
            r_tx_bitidx <= r_tx_bitidx + 3'd1;
            if (r_tx_bitidx == 3'd7) begin
              r_tx <= r_tx_par_en ? r_tx_par : 1'b1;
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end
          default: r_tx <= 1'b1;  // parity -> stop, or stop -> idle
        endcase
      end
    end
  end

  // ---------------- RX FSM ----------------
  state_t           r_rx_state, w_rx_next;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div;
  logic [2:0]       r_rx_bitidx;
  logic             r_rx_par_en, r_rx_par_odd, r_rx_par_bad;
  logic             w_rx_bit_end, w_rx_fall;

  assign w_rx_bit_end = (r_rx_cnt == '0);
  assign w_rx_fall    = r_rx_prev & ~r_rx_s2;

  // RX next state; pushes the byte at the stop-bit sample
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (w_rx_fall) w_rx_next = S_START;
        else           w_rx_next = S_IDLE;
      end
      S_START: begin
        if (w_rx_bit_end) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;  // high = glitch
        else              w_rx_next = S_START;
      end
      S_DATA: begin
        if (w_rx_bit_end && (r_rx_bitidx == 3'd7)) w_rx_next = r_rx_par_en ? S_PARITY : S_STOP;
        else                                       w_rx_next = S_DATA;
      end
      S_PARITY: begin
        if (w_rx_bit_end) w_rx_next = S_STOP;
        else              w_rx_next = S_PARITY;
      end
      S_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_next = S_IDLE;
          w_rx_push = 1'b1;
        end else begin
          w_rx_next = S_STOP;
        end
      end
      default: w_rx_next = S_IDLE;
    endcase
  end

  // RX synchroniser, state register, mid-bit sampling and shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_div     <= '0;
      r_rx_shift   <= 8'h00;
      r_rx_bitidx  <= 3'd0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_bad <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_next;
      if (r_rx_state == S_IDLE) begin
        if (w_rx_fall) begin
          r_rx_cnt     <= r_div >> 1;  // first sample lands mid start bit
          r_rx_div     <= r_div;
          r_rx_par_en  <= r_ctrl[0];
          r_rx_par_odd <= r_ctrl[1];
          r_rx_bitidx  <= 3'd0;
          r_rx_par_bad <= 1'b0;
        end
      end else if (!w_rx_bit_end) begin
        r_rx_cnt <= r_rx_cnt - DIV_ONE;
      end else begin
        r_rx_cnt <= r_rx_div;
        case (r_rx_state)
          S_DATA: begin
            r_rx_shift  <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bitidx <= r_rx_bitidx + 3'd1;
          end
          S_PARITY: r_rx_par_bad <= r_rx_s2 ^ (^r_rx_shift) ^ r_rx_par_odd;
          default: ;
        endcase
      end
    end
  end

  // ---------------- registers, flags, read port ----------------
  assign w_tx_busy = ~w_txf_empty | (r_tx_state != S_IDLE);
  assign w_stat = {1'b0, w_txf_empty, r_par_err, r_frame_err, r_overrun,
                   w_txf_full, ~w_rxf_empty, w_tx_busy};

  // DIV and CTRL configuration writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= DIV_RST;
      r_ctrl <= 2'b00;
    end else if (wen) begin
      case (addr)
        A_DIVL:  r_div[7:0]       <= wdata;
        A_DIVH:  r_div[DIV_W-1:8] <= wdata[DIV_W-9:0];
        A_CTRL:  r_ctrl           <= wdata[1:0];
        default: ;
      endcase
    end
  end

  // sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_overrun   <= (w_rx_push & ~w_rxf_push_ok)         | (r_overrun   & ~w_clr_flags);
      r_frame_err <= (w_rx_push & ~r_rx_s2)                | (r_frame_err & ~w_clr_flags);
      r_par_err   <= (w_rx_push & r_rx_par_en & r_rx_par_bad) | (r_par_err & ~w_clr_flags);
    end
  end

  // registered read response, one cycle after ren
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= ren;
      if (ren) begin
        case (addr)
          A_DATA:  r_rdata <= w_rxf_empty ? 8'h00 : w_rxf_data;
          A_STAT:  r_rdata <= w_stat;
          A_DIVL:  r_rdata <= r_div[7:0];
          A_DIVH:  r_rdata <= 8'(r_div[DIV_W-1:8]);
          A_CTRL:  r_rdata <= {6'b000000, r_ctrl};
          default: r_rdata <= 8'h00;
        endcase
      end
    end
  end

  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo: register map, TX framing,
// loopback bursts, overrun, framing/glitch handling and parity.

module tb_uart_fifo;

  localparam logic [4:0] A_DATA = 5'h00;
  localparam logic [4:0] A_STAT = 5'h04;
  localparam logic [4:0] A_DIVL = 5'h08;
  localparam logic [4:0] A_DIVH = 5'h0C;
  localparam logic [4:0] A_CTRL = 5'h10;
  localparam logic [4:0] A_BAD  = 5'h14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] addr = 5'h00;
  logic       ren = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       tx;
  logic       rx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;

  int checks = 0;
  int failures = 0;

  assign rx = loop_en ? tx : rx_drv;

  uart_fifo dut (
    .clk(clk), .rst(rst), .addr(addr), .ren(ren), .rdata(rdata),
    .rd_valid(rd_valid), .wen(wen), .wdata(wdata), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick(1);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
    addr = a; ren = 1'b1;
    tick(1);
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_en, input logic par_bit,
                            input logic stop_bit, input int bt);
    rx_drv = 1'b0; tick(bt);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i]; tick(bt);
    end
    if (par_en) begin
      rx_drv = par_bit; tick(bt);
    end
    rx_drv = stop_bit; tick(bt);
    rx_drv = 1'b1; tick(2);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tick(3);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    rst = 1'b0;
    tick(2);
    bus_read(A_STAT, d);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL rd_valid_pulse: got %b expected 1", rd_valid); end
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL reset_stat: got %h expected 40", d); end
    tick(1);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_one_cycle: got %b expected 0", rd_valid); end
    bus_read(A_DIVL, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL reset_divl: got %h expected 0f", d); end
    bus_read(A_DIVH, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_divh: got %h expected 00", d); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx_idle: got %b expected 1", tx); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    bus_write(A_DIVL, 8'h34);
    bus_read(A_DIVL, d);
    checks++; if (d !== 8'h34) begin failures++; $display("FAIL divl_rw: got %h expected 34", d); end
    bus_write(A_DIVH, 8'h12);
    bus_read(A_DIVH, d);
    checks++; if (d !== 8'h12) begin failures++; $display("FAIL divh_rw: got %h expected 12", d); end
    bus_write(A_CTRL, 8'h1F);
    bus_read(A_CTRL, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL ctrl_rw: got %h expected 03", d); end
    bus_write(A_BAD, 8'hFF);
    bus_read(A_BAD, d);
    checks++; if (d !== 8'h00 || rd_valid !== 1'b1) begin failures++; $display("FAIL unmapped_read: got %h/%b expected 00/1", d, rd_valid); end
    bus_read(A_DATA, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rx_empty_read: got %h expected 00", d); end
    // read and write in the same cycle: old value returned, new value stored
    addr = A_DIVL; wdata = 8'h56; wen = 1'b1; ren = 1'b1;
    tick(1);
    wen = 1'b0; ren = 1'b0;
    checks++; if (rdata !== 8'h34) begin failures++; $display("FAIL ren_wen_read: got %h expected 34", rdata); end
    bus_read(A_DIVL, d);
    checks++; if (d !== 8'h56) begin failures++; $display("FAIL ren_wen_write: got %h expected 56", d); end
    bus_write(A_CTRL, 8'h00);
    bus_write(A_DIVH, 8'h00);
  endtask

  task automatic test_tx_frame();
    logic [7:0] d;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    bus_write(A_DIVL, 8'h03);
    bus_write(A_DATA, 8'hA5);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL tx_stat_busy: got %h expected 01", d); end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (tx !== exp_bits[k/4]) begin
        failures++; $display("FAIL tx_bit clk %0d: got %b expected %b", k, tx, exp_bits[k/4]);
      end
      tick(1);
    end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL tx_stat_done: got %h expected 40", d); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL tx_idle_after: got %b expected 1", tx); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    bus_write(A_DATA, 8'h55);
    tick(1);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL midframe_start: got %b expected 0", tx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midframe_async_tx: got %b expected 1", tx); end
    tick(1);
    rst = 1'b0;
    tick(1);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL midframe_stat: got %h expected 40", d); end
    bus_read(A_DIVL, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL midframe_divl: got %h expected 0f", d); end
  endtask

  task automatic test_loopback_burst();
    logic [7:0] d;
    logic done;
    bus_write(A_DIVL, 8'h07);
    bus_write(A_CTRL, 8'h18);
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 8'(i));
    bus_read(A_STAT, d);
    checks++; if (d[2] !== 1'b1) begin failures++; $display("FAIL burst_tx_full: got %b expected 1", d[2]); end
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      bus_read(A_STAT, d);
      if (d[0] == 1'b0) done = 1'b1;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL burst_drain_timeout: got %b expected 1", done); end
    tick(20);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, d);
      checks++; if (d !== 8'(i)) begin failures++; $display("FAIL burst_rx[%0d]: got %h expected %h", i, d, 8'(i)); end
    end
    bus_read(A_STAT, d);
    checks++; if (d[1] !== 1'b0) begin failures++; $display("FAIL burst_no_extra: got %b expected 0", d[1]); end
    loop_en = 1'b0;
    bus_write(A_CTRL, 8'h18);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i < 17; i++) send_frame(8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 8);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h4A) begin failures++; $display("FAIL overrun_stat: got %h expected 4a", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, d);
      checks++; if (d !== 8'(8'h80 + i)) begin failures++; $display("FAIL overrun_rx[%0d]: got %h expected %h", i, d, 8'(8'h80 + i)); end
    end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h48) begin failures++; $display("FAIL overrun_sticky: got %h expected 48", d); end
    bus_write(A_CTRL, 8'h10);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL overrun_clear: got %h expected 40", d); end
  endtask

  task automatic test_framing_glitch();
    logic [7:0] d;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8);
    bus_read(A_DATA, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL framing_byte: got %h expected 3c", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h50) begin failures++; $display("FAIL framing_stat: got %h expected 50", d); end
    bus_write(A_CTRL, 8'h10);
    rx_drv = 1'b0; tick(1);
    rx_drv = 1'b1; tick(120);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL glitch_stat: got %h expected 40", d); end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic found;
    bus_write(A_CTRL, 8'h03);
    loop_en = 1'b1;
    bus_write(A_DATA, 8'h07);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (tx === 1'b0) found = 1'b1;
      else tick(1);
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL parity_start_timeout: got %b expected 1", found); end
    tick(9 * 8 + 4);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL parity_tx_bit: got %b expected 0", tx); end
    tick(8);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL parity_tx_stop: got %b expected 1", tx); end
    tick(20);
    bus_read(A_DATA, d);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL parity_loop_byte: got %h expected 07", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL parity_loop_stat: got %h expected 40", d); end
    rx_drv = 1'b1;
    loop_en = 1'b0;
    tick(4);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 8);
    bus_read(A_DATA, d);
    checks++; if (d !== 8'h07) begin failures++; $display("FAIL parity_err_byte: got %h expected 07", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h60) begin failures++; $display("FAIL parity_err_stat: got %h expected 60", d); end
    bus_write(A_CTRL, 8'h10);
    bus_read(A_STAT, d);
    checks++; if (d !== 8'h40) begin failures++; $display("FAIL parity_clear: got %h expected 40", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_reset_midframe();
    test_loopback_burst();
    test_overrun();
    test_framing_glitch();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
